// File: rtl/aes_word_adapter.sv
// ---------------------------------------------------------------------------
// aes_word_adapter
//
// Stream front/back end for an AES-128 core. Eight 32-bit input words
// (key then plaintext, most significant word first) are assembled into
// core_key / core_plain. The core is then started with a one-cycle
// core_valid pulse. The cipher text captured on core_done is emitted as
// four 32-bit words on the output stream, most significant word first.
// If the core does not answer within TIMEOUT_CYC cycles, the block is
// abandoned and the sticky err_timeout flag is raised.
//
// Optional build macro: AES_ADAPT_KEY_REUSE_EN
//   Adds input s_new_key. It is sampled on the first word of a block.
//   When it is 0, the previous key is kept and the block is 4 plaintext
//   words only.
//
// Ports:
//   CLK, rst_n              clock, asynchronous active-low reset
//   s_valid/s_ready/s_data  32-bit input word stream
//   s_new_key               (macro only) 1 = block carries a new key
//   m_valid/m_ready/m_data  32-bit cipher word stream
//   m_last                  marks the 4th cipher word
//   core_valid              one-cycle start pulse to the core
//   core_key, core_plain    operands, stable from the pulse until done
//   core_cypher, core_done  result and completion pulse from the core
//   core_busy               core cannot accept a start
//   err_timeout, err_clr    sticky timeout flag and its clear
// ---------------------------------------------------------------------------
module aes_word_adapter #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic         CLK,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
`ifdef AES_ADAPT_KEY_REUSE_EN
  input  logic         s_new_key,
`endif
  output logic         m_valid,
  input  logic         m_ready,
  output logic [31:0]  m_data,
  output logic         m_last,
  output logic         core_valid,
  output logic [127:0] core_key,
  output logic [127:0] core_plain,
  input  logic [127:0] core_cypher,
  input  logic         core_done,
  input  logic         core_busy,
  output logic         err_timeout,
  input  logic         err_clr
);

  typedef enum logic [2:0] {
    LD_KEY = 3'd0,
    LD_TXT = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Writes word w into 32-bit slot idx of a block; slot 0 is bits [127:96].
  function automatic logic [127:0] put_word(input logic [127:0] blk,
                                            input logic [1:0]   idx,
                                            input logic [31:0]  w);
    logic [127:0] r;
    r = blk;
    case (idx)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      2'd3:    r[31:0]   = w;
      default: r = blk;
    endcase
    return r;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [1:0]       word_cnt_r, word_cnt_nxt_s;
  logic [CNT_W-1:0] to_cnt_r, to_cnt_nxt_s;
  logic [127:0]     key_r, key_nxt_s;
  logic [127:0]     plain_r, plain_nxt_s;
  logic [127:0]     shift_r, shift_nxt_s;
  logic [31:0]      m_data_r, m_data_nxt_s;
  logic             m_valid_r, m_valid_nxt_s;
  logic             m_last_r, m_last_nxt_s;
  logic             core_valid_r, core_valid_nxt_s;
  logic             err_r, err_nxt_s, err_set_s;
  logic             s_ready_r, s_ready_nxt_s;
  logic             in_xfer_s, out_xfer_s, reuse_s;

`ifdef AES_ADAPT_KEY_REUSE_EN
  assign reuse_s = ~s_new_key;
`else
  assign reuse_s = 1'b0;
`endif

  assign in_xfer_s  = s_valid & s_ready_r;
  assign out_xfer_s = m_valid_r & m_ready;

  // Next-state and next-output computation for every register.
  always_comb begin
    state_nxt_s      = state_r;
    word_cnt_nxt_s   = word_cnt_r;
    to_cnt_nxt_s     = to_cnt_r;
    key_nxt_s        = key_r;
    plain_nxt_s      = plain_r;
    shift_nxt_s      = shift_r;
    m_data_nxt_s     = m_data_r;
    m_valid_nxt_s    = m_valid_r;
    m_last_nxt_s     = m_last_r;
    core_valid_nxt_s = 1'b0;
    err_set_s        = 1'b0;

    case (state_r)
      LD_KEY: begin
        if (in_xfer_s) begin
          if ((word_cnt_r == 2'd0) && reuse_s) begin
            // Key kept from the previous block; this word opens the plaintext.
            plain_nxt_s    = put_word(plain_r, 2'd0, s_data);
            word_cnt_nxt_s = 2'd1;
            state_nxt_s    = LD_TXT;
          end else begin
            key_nxt_s = put_word(key_r, word_cnt_r, s_data);
            if (word_cnt_r == 2'd3) begin
              word_cnt_nxt_s = 2'd0;
              state_nxt_s    = LD_TXT;
            end else begin
              word_cnt_nxt_s = word_cnt_r + 2'd1;
            end
          end
        end else begin
          state_nxt_s = LD_KEY;
        end
      end

      LD_TXT: begin
        if (in_xfer_s) begin
          plain_nxt_s = put_word(plain_r, word_cnt_r, s_data);
          if (word_cnt_r == 2'd3) begin
            word_cnt_nxt_s = 2'd0;
            // Issue the start pulse straight away when the core is free, so
            // core_valid is seen the cycle after the last input word.
            if (!core_busy) begin
              core_valid_nxt_s = 1'b1;
              to_cnt_nxt_s     = CNT_ZERO;
              state_nxt_s      = WAIT;
            end else begin
              state_nxt_s = START;
            end
          end else begin
            word_cnt_nxt_s = word_cnt_r + 2'd1;
          end
        end else begin
          state_nxt_s = LD_TXT;
        end
      end

      START: begin
        if (!core_busy) begin
          core_valid_nxt_s = 1'b1;
          to_cnt_nxt_s     = CNT_ZERO;
          state_nxt_s      = WAIT;
        end else begin
          state_nxt_s = START;
        end
      end

      WAIT: begin
        // core_done is tested first so that it wins over a coincident timeout.
        if (core_done) begin
          shift_nxt_s    = core_cypher;
          m_data_nxt_s   = core_cypher[127:96];
          m_valid_nxt_s  = 1'b1;
          m_last_nxt_s   = 1'b0;
          word_cnt_nxt_s = 2'd0;
          state_nxt_s    = DRAIN;
        end else if (to_cnt_r == TO_LAST) begin
          err_set_s      = 1'b1;
          to_cnt_nxt_s   = CNT_ZERO;
          word_cnt_nxt_s = 2'd0;
          state_nxt_s    = LD_KEY;
        end else begin
          to_cnt_nxt_s = to_cnt_r + CNT_ONE;
        end
      end

      DRAIN: begin
        if (out_xfer_s) begin
          shift_nxt_s  = {shift_r[95:0], 32'h0000_0000};
          m_data_nxt_s = shift_r[95:64];
          if (word_cnt_r == 2'd3) begin
            m_valid_nxt_s  = 1'b0;
            m_last_nxt_s   = 1'b0;
            word_cnt_nxt_s = 2'd0;
            state_nxt_s    = LD_KEY;
          end else begin
            m_last_nxt_s   = (word_cnt_r == 2'd2);
            word_cnt_nxt_s = word_cnt_r + 2'd1;
          end
        end else begin
          state_nxt_s = DRAIN;
        end
      end

      default: begin
        state_nxt_s    = LD_KEY;
        word_cnt_nxt_s = 2'd0;
      end
    endcase

    // Set has priority over a same-cycle clear.
    err_nxt_s     = err_set_s | (err_r & ~err_clr);
    s_ready_nxt_s = (state_nxt_s == LD_KEY) || (state_nxt_s == LD_TXT);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= LD_KEY;
      word_cnt_r   <= 2'd0;
      to_cnt_r     <= CNT_ZERO;
      key_r        <= 128'd0;
      plain_r      <= 128'd0;
      shift_r      <= 128'd0;
      m_data_r     <= 32'd0;
      m_valid_r    <= 1'b0;
      m_last_r     <= 1'b0;
      core_valid_r <= 1'b0;
      err_r        <= 1'b0;
      s_ready_r    <= 1'b1;
    end else begin
      state_r      <= state_nxt_s;
      word_cnt_r   <= word_cnt_nxt_s;
      to_cnt_r     <= to_cnt_nxt_s;
      key_r        <= key_nxt_s;
      plain_r      <= plain_nxt_s;
      shift_r      <= shift_nxt_s;
      m_data_r     <= m_data_nxt_s;
      m_valid_r    <= m_valid_nxt_s;
      m_last_r     <= m_last_nxt_s;
      core_valid_r <= core_valid_nxt_s;
      err_r        <= err_nxt_s;
      s_ready_r    <= s_ready_nxt_s;
    end
  end

  assign s_ready     = s_ready_r;
  assign m_valid     = m_valid_r;
  assign m_data      = m_data_r;
  assign m_last      = m_last_r;
  assign core_valid  = core_valid_r;
  assign core_key    = key_r;
  assign core_plain  = plain_r;
  assign err_timeout = err_r;

endmodule

// File: tb/tb_aes_word_adapter.sv
// ---------------------------------------------------------------------------
// tb_aes_word_adapter
//
// Self-checking bench for aes_word_adapter. A behavioural core model answers
// core_valid pulses with a cipher block. It knows two FIPS-197 vectors and
// uses a keyed mixing function otherwise. Block expectations come from a
// vector table and from randomized blocks. A sink process applies output
// backpressure, records output words and checks that stalled outputs stay
// stable.
// ---------------------------------------------------------------------------
module tb_aes_word_adapter;

  localparam logic [127:0] FIPS_KEY = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  localparam logic [127:0] B_KEY    = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] B_PT     = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] B_CT     = 128'h3925841d_02dc09fb_dc118597_196a0b32;

  logic         CLK, rst_n;
  logic         s_valid, s_ready, m_valid, m_ready, m_last;
  logic [31:0]  s_data, m_data;
  logic         core_valid, core_done, core_busy, err_timeout, err_clr;
  logic [127:0] core_key, core_plain, core_cypher;
`ifdef AES_ADAPT_KEY_REUSE_EN
  logic         s_new_key;
`endif

  int n_chk = 0, n_pass = 0;
  int cyc = 0, cv_cnt = 0, done_cyc = 0, mv_cyc = 0, pidx = 0;
  int rdy_mode = 0, core_lat = 0;
  bit core_mute = 1'b0, stray_req = 1'b0, mv_seen = 1'b0;
  logic [31:0]  got_q[$];
  logic         last_q[$];
  logic [127:0] ck, cp;

  aes_word_adapter #(.TIMEOUT_CYC(64), .CNT_W(7)) dut (
    .CLK(CLK), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
`ifdef AES_ADAPT_KEY_REUSE_EN
    .s_new_key(s_new_key),
`endif
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .core_valid(core_valid), .core_key(core_key), .core_plain(core_plain),
    .core_cypher(core_cypher), .core_done(core_done), .core_busy(core_busy),
    .err_timeout(err_timeout), .err_clr(err_clr)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Reference core: known answers for the FIPS vectors, a keyed mix otherwise.
  function automatic logic [127:0] cipher_fn(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    if (k == B_KEY && p == B_PT) return B_CT;
    return k ^ {p[63:0], p[127:64]} ^ 128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c;
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] blk, input int i);
    return blk[127 - 32*i -: 32];
  endfunction

  // Core model: answers core_valid after core_lat cycles, or a stray done on request.
  initial begin
    core_done = 1'b0;
    core_cypher = 128'd0;
    forever begin
      @(negedge CLK);
      if (stray_req) begin
        core_cypher = {4{32'hdeadbeef}};
        core_done = 1'b1;
        @(negedge CLK);
        core_done = 1'b0;
        stray_req = 1'b0;
      end else if (core_valid && !core_mute) begin
        ck = core_key;
        cp = core_plain;
        repeat (core_lat) @(negedge CLK);
        core_cypher = cipher_fn(ck, cp);
        core_done = 1'b1;
        done_cyc = cyc;
        @(negedge CLK);
        core_done = 1'b0;
      end
    end
  end

  // Counts core_valid pulses.
  initial begin
    forever begin
      @(negedge CLK);
      if (core_valid) cv_cnt++;
    end
  end

  // Output sink: drives m_ready, records transfers, checks stall stability.
  initial begin
    logic        prev_stall, prev_mv, prev_last;
    logic [31:0] prev_data;
    logic [3:0]  pat;
    pat = 4'b1001;
    prev_stall = 1'b0; prev_mv = 1'b0; prev_last = 1'b0; prev_data = 32'd0;
    m_ready = 1'b0;
    forever begin
      @(negedge CLK);
      if (prev_stall)
        check("stall_hold", {m_valid, m_last, m_data}, {1'b1, prev_last, prev_data});
      if (m_valid && !prev_mv) mv_cyc = cyc;
      if (m_valid) mv_seen = 1'b1;
      prev_mv = m_valid;
      case (rdy_mode)
        1:       m_ready = pat[pidx % 4];
        2:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
      pidx++;
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        last_q.push_back(m_last);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  // Presents one word (after gap idle cycles) and returns after it transfers.
  task automatic send_word(input logic [31:0] w, input int gap, input bit nk);
    int t;
    s_valid = 1'b0;
    repeat (gap) @(negedge CLK);
    s_valid = 1'b1;
    s_data = w;
`ifdef AES_ADAPT_KEY_REUSE_EN
    s_new_key = nk;
`endif
    t = 0;
    while (!s_ready && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 50) check("s_ready_wait", s_ready, 1'b1);
    @(negedge CLK);
    s_valid = 1'b0;
  endtask

  task automatic run_block(input logic [127:0] key, input logic [127:0] pt,
                           input logic [127:0] ct, input int busy, input int lat,
                           input int rdy, input int gap, input bit reuse);
    int cv0, t;
    cv0 = cv_cnt;
    got_q.delete();
    last_q.delete();
    rdy_mode = rdy;
    core_lat = lat;
    core_busy = (busy > 0);
    if (!reuse)
      for (int i = 0; i < 4; i++) send_word(word_of(key, i), gap, (i == 0));
    for (int i = 0; i < 4; i++) send_word(word_of(pt, i), gap, !(reuse && i == 0));
    for (int i = 0; i < busy; i++) begin
      check("busy_hold", core_valid, 1'b0);
      if (i == busy - 1) core_busy = 1'b0;
      @(negedge CLK);
    end
    check("core_valid_pulse", core_valid, 1'b1);
    check("core_key", core_key, key);
    check("core_plain", core_plain, pt);
    t = 0;
    while (got_q.size() < 4 && t < 400) begin
      @(negedge CLK);
      t++;
    end
    @(negedge CLK);
    @(negedge CLK);
    check("out_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      check("m_data_word", got_q[i], word_of(ct, i));
      check("m_last_flag", last_q[i], (i == 3));
    end
    check("core_valid_count", cv_cnt - cv0, 1);
    check("m_valid_latency", mv_cyc - done_cyc, 1);
    check("idle_after_drain", {s_ready, m_valid, m_last}, 3'b100);
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int           busy;
    int           lat;
    int           rdy;
    int           gap;
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0] = '{FIPS_KEY, FIPS_PT, FIPS_CT, 0, 2, 0, 0};   // plain FIPS-197 run
    vt[1] = '{FIPS_KEY, FIPS_PT, FIPS_CT, 0, 0, 1, 2};   // 1,0,0,1 backpressure + gaps
    vt[2] = '{FIPS_KEY, FIPS_PT, FIPS_CT, 5, 3, 0, 0};   // core busy for 5 cycles
    vt[3] = '{FIPS_KEY, FIPS_PT, FIPS_CT, 0, 63, 0, 0};  // done coincides with timeout
    vt[4] = '{B_KEY, B_PT, B_CT, 1, 1, 2, 1};            // FIPS-197 appendix B
    vt[5] = '{128'hffffffff_00000000_12345678_9abcdef0, 128'h0, 128'h0, 2, 7, 1, 0};
    vt[5].ct = cipher_fn(vt[5].key, vt[5].pt);

    rst_n = 1'b0; s_valid = 1'b0; s_data = 32'd0; core_busy = 1'b0; err_clr = 1'b0;
`ifdef AES_ADAPT_KEY_REUSE_EN
    s_new_key = 1'b1;
`endif
    repeat (3) @(negedge CLK);
    check("reset_flags", {s_ready, m_valid, m_last, core_valid, err_timeout}, 5'b10000);
    check("reset_key", core_key, 128'd0);
    check("reset_plain", core_plain, 128'd0);
    check("reset_m_data", m_data, 32'd0);
    rst_n = 1'b1;
    @(negedge CLK);
    check("post_reset_flags", {s_ready, m_valid, core_valid}, 3'b100);

    for (int v = 0; v < 6; v++) begin
      run_block(vt[v].key, vt[v].pt, vt[v].ct, vt[v].busy, vt[v].lat, vt[v].rdy, vt[v].gap, 1'b0);
      check("no_err_after_block", err_timeout, 1'b0);
    end

    // core_done outside WAIT is ignored.
    mv_seen = 1'b0;
    stray_req = 1'b1;
    repeat (4) @(negedge CLK);
    check("stray_done_ignored", {mv_seen, s_ready}, 2'b01);

    // Core never answers: timeout exactly 64 cycles after core_valid.
    begin
      int cv0;
      bit early;
      core_mute = 1'b1; mv_seen = 1'b0; cv0 = cv_cnt; early = 1'b0;
      for (int i = 0; i < 4; i++) send_word(word_of(FIPS_KEY, i), 0, (i == 0));
      for (int i = 0; i < 4; i++) send_word(word_of(FIPS_PT, i), 0, 1'b1);
      check("to_core_valid", core_valid, 1'b1);
      for (int k = 1; k < 64; k++) begin
        @(negedge CLK);
        if (err_timeout || s_ready) early = 1'b1;
      end
      check("to_not_early", early, 1'b0);
      @(negedge CLK);
      check("to_err_set", {err_timeout, s_ready}, 2'b11);
      err_clr = 1'b1;
      @(negedge CLK);
      err_clr = 1'b0;
      check("to_err_cleared", err_timeout, 1'b0);
      check("to_no_output", mv_seen, 1'b0);
      check("to_single_pulse", cv_cnt - cv0, 1);

      // Clear held high across the timeout edge: set still wins.
      err_clr = 1'b1;
      for (int i = 0; i < 4; i++) send_word(word_of(B_KEY, i), 0, (i == 0));
      for (int i = 0; i < 4; i++) send_word(word_of(B_PT, i), 0, 1'b1);
      repeat (64) @(negedge CLK);
      check("to_set_wins", err_timeout, 1'b1);
      @(negedge CLK);
      check("to_clr_after_set", err_timeout, 1'b0);
      err_clr = 1'b0;
      core_mute = 1'b0;
    end

    // Reset after the 5th input word discards the partial block.
    begin
      int cv0;
      cv0 = cv_cnt;
      for (int i = 0; i < 4; i++) send_word(word_of(B_KEY, i), 0, (i == 0));
      send_word(word_of(B_PT, 0), 0, 1'b1);
      rst_n = 1'b0;
      @(negedge CLK);
      check("mid_reset_flags", {s_ready, m_valid, m_last, core_valid, err_timeout}, 5'b10000);
      check("mid_reset_key", core_key, 128'd0);
      check("mid_reset_plain", core_plain, 128'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge CLK);
      check("mid_reset_no_pulse", cv_cnt - cv0, 0);
      run_block(FIPS_KEY, FIPS_PT, FIPS_CT, 0, 2, 0, 0, 1'b0);
    end

`ifdef AES_ADAPT_KEY_REUSE_EN
    run_block(FIPS_KEY, FIPS_PT, FIPS_CT, 0, 1, 0, 0, 1'b0);
    check("reuse_key_kept", core_key, FIPS_KEY);
    run_block(FIPS_KEY, FIPS_PT, FIPS_CT, 0, 1, 1, 1, 1'b1);
`endif

    // Randomized blocks against the reference model.
    for (int r = 0; r < 12; r++) begin
      logic [127:0] k, p;
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      run_block(k, p, cipher_fn(k, p), $urandom_range(0, 3), $urandom_range(0, 8),
                2, $urandom_range(0, 2), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    n_chk++;
    $display("FAIL watchdog: time limit reached, got %0d checks, expected completion", n_chk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_word_adapter.md
Name: aes_word_adapter

Overview:
- Stream front/back end for the AES-128 core.
- Accepts 32-bit words on a ready/valid input stream, assembles the 128-bit key and plaintext, and pulses the core's Valid.
- Captures the cipher text on Done and serialises it as four 32-bit words on a ready/valid output stream.
- Sits directly between the system bus/DMA and the core's Key, Plain_txt, Valid, Cypher_txt, Done and Busy ports.

Parameters:
- TIMEOUT_CYC, 64: max cycles waited for core_done after the Valid pulse before aborting.
- CNT_W, 7: width of the timeout counter; must hold TIMEOUT_CYC.

Ports:
- CLK  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input word valid
- s_ready  out  1  adapter can accept a word
- s_data  in  32  input word
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts word
- m_data  out  32  output cipher word
- m_last  out  1  high with 4th output word
- core_valid  out  1  one-cycle start pulse to core Valid
- core_key  out  128  to core Key, held stable from pulse until done
- core_plain  out  128  to core Plain_txt, held stable likewise
- core_cypher  in  128  from core Cypher_txt
- core_done  in  1  from core Done (one-cycle pulse)
- core_busy  in  1  from core Busy
- err_timeout  out  1  sticky: core failed to finish in TIMEOUT_CYC
- err_clr  in  1  clears err_timeout

Behaviour:
- Clock CLK; reset rst_n asynchronous, active-low.
- Reset values:
  - state = LD_KEY; word counter = 0; timeout counter = 0.
  - core_key = 0, core_plain = 0, output shift register = 0.
  - core_valid = 0, m_valid = 0, m_last = 0, m_data = 0, err_timeout = 0.
  - s_ready = 1 (decoded from state).
- Reset mid-operation: everything returns to the above at once. A partially loaded block is discarded and no core_valid is issued.
- Word order: first word is bits [127:96], fourth is [31:0], for key, plaintext and cipher alike.
- A transfer occurs on s_valid && s_ready (input) or m_valid && m_ready (output).
- States:
  - LD_KEY: s_ready = 1. Each transfer shifts s_data into core_key at the next slot. After the 4th word go to LD_TXT, counter = 0.
  - LD_TXT: s_ready = 1. Same, into core_plain. After the 4th word go to START.
  - START: s_ready = 0. If core_busy = 0, drive core_valid = 1 for exactly one cycle, clear the timeout counter, go to WAIT. If core_busy = 1, remain in START without pulsing.
  - WAIT: s_ready = 0; the timeout counter increments each cycle.
    - On core_done = 1, latch core_cypher into the shift register and go to DRAIN.
    - If the counter reaches TIMEOUT_CYC first, set err_timeout and go to LD_KEY; no output words are produced.
    - If core_done and timeout coincide, core_done wins.
  - DRAIN: m_valid = 1; m_data = shift register [127:96]. Each output transfer shifts left by 32. m_last = 1 on the 4th word. After the 4th transfer, m_valid = 0 and state goes to LD_KEY.
- Stalls:
  - m_ready = 0 holds m_data/m_last stable.
  - s_valid = 0 holds the input counter.
  - No input is accepted while in DRAIN (no overlap).
- core_done outside WAIT is ignored.
- core_key and core_plain change only on input transfers.
- Latency, from the 8th input transfer:
  - core_valid asserts the next cycle if core_busy = 0.
  - m_valid asserts the cycle after core_done.
- err_clr clears err_timeout next cycle; if set and clear occur in the same cycle, set wins.

Optional Feature:
- Macro: AES_ADAPT_KEY_REUSE_EN.
- When defined:
  - Adds input port s_new_key (1 bit), sampled on the first transfer of a block in LD_KEY.
  - If s_new_key = 1, that word is key word 0 and the block proceeds as normal.
  - If s_new_key = 0, core_key is retained and that word is plaintext word 0; state jumps to LD_TXT with counter = 1.
  - After reset core_key = 0, so reuse without a prior load encrypts under the all-zero key.
- When undefined: no s_new_key port; every block is 8 input words.

Test Plan:
- FIPS-197 vector: key words 00010203, 04050607, 08090a0b, 0c0d0e0f; plaintext 00112233, 44556677, 8899aabb, ccddeeff; core model returns cipher on done. Required: core_valid pulses once with the correct key/plain; m_data = 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a; m_last only on the 4th word.
- Backpressure: m_ready toggled 1,0,0,1,… and s_valid gaps inserted. Required: no word lost or duplicated; m_data stable while stalled; same output as above.
- core_busy held 1 for 5 cycles on entry to START. Required: core_valid stays 0 for those 5 cycles, then pulses exactly once.
- core_done never asserted, TIMEOUT_CYC = 64. Required: err_timeout = 1 exactly 64 cycles after core_valid; s_ready = 1 next cycle; m_valid never asserts; err_clr then drives err_timeout to 0.
- rst_n pulsed low after the 5th input word. Required: all outputs return to reset values; the following 8-word block encrypts correctly with no stray core_valid.
- With AES_ADAPT_KEY_REUSE_EN: block 1 sent with s_new_key = 1; block 2 sent as 4 words with s_new_key = 0 and the same plaintext. Required: core_key unchanged and block 2 output = 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a.
